fetch_stage: RTL

Instruction-fetch stage of the ARM pipeline. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned word with its PC into the IF/ID pipeline register for decode. Supports decode-side stall and execute-side branch redirect with flush of the wrong-path instruction.

---
 rtl/arm_pkg.sv | 14 +
 rtl/fetch_stage_pc_register.sv | 40 ++++
 rtl/fetch_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: constants and types shared by the ARM pipeline stages.
//   ARM_NOP        - MOV r0,r0 encoding, used as the bubble instruction
//   PC_STEP        - sequential fetch increment in bytes
//   PC_R15_OFFSET  - ARM reads R15 as the address of the instruction plus 8
//   word_t         - 32-bit machine word
package arm_pkg;

  typedef logic [31:0] word_t;

  localparam word_t ARM_NOP       = 32'hE1A0_0000;
  localparam word_t PC_STEP       = 32'd4;
  localparam word_t PC_R15_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// pc_register: program counter flop for the fetch stage.
// Priority on each rising edge: reset > branch_taken > stall > sequential.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   stall          - hold the PC
//   branch_taken   - load the redirect target (word aligned)
//   branch_target  - redirect address; bits [1:0] are ignored
//   pc             - current program counter
module pc_register
  import arm_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  branch_taken,
  input  word_t branch_target,
  output word_t pc
);

  word_t r_pc;
  word_t w_target_aligned;

  // Masking rather than slicing keeps the full target bus in use.
  assign w_target_aligned = branch_target & ~word_t'(32'h3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (branch_taken) begin
      r_pc <= w_target_aligned;
    end else if (!stall) begin
      r_pc <= r_pc + PC_STEP;   // wraps modulo 2^32
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Drives the PC onto the combinational
// instruction memory and registers the returned word plus its PC into the
// IF/ID register. Branch redirect flushes the wrong-path word; stall freezes.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   stall            - hold PC and IF/ID register (hazard unit)
//   branch_taken     - redirect from execute, wins over stall
//   branch_target    - redirect address
//   imem_addr        - byte address to instruction memory (= PC)
//   imem_rd          - instruction word returned in the same cycle
//   instr_d, pc_d    - registered instruction and its PC
//   pc_plus8_d       - pc_d + 8 (R15 read value)
//   valid_d          - instr_d is a real fetched instruction
// Optional (macro FETCH_PERF_CNT_EN):
//   fetch_count      - edges on which valid_d was loaded with 1
//   flush_count      - edges with branch_taken and no reset
//
// Handshake: there is no ready input; valid_d=1 means instr_d/pc_d hold a
// real instruction. While stall is high the stage holds its outputs, so
// decode sees the same instruction again rather than a new one; an
// instruction is consumed exactly once, on an edge where stall is low.
module fetch_stage
  import arm_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = ARM_NOP
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  branch_taken,
  input  word_t branch_target,
  output word_t imem_addr,
  input  word_t imem_rd,
  output word_t instr_d,
  output word_t pc_d,
  output word_t pc_plus8_d,
  output logic  valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output word_t fetch_count,
  output word_t flush_count
`endif
);

  word_t w_pc;
  word_t r_instr_d;
  word_t r_pc_d;
  logic  r_valid_d;
  logic  w_load;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (w_pc)
  );

  // A real instruction is captured only on a plain sequential edge.
  assign w_load = !reset && !branch_taken && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= RESET_PC;
      r_valid_d <= 1'b0;
    end else if (branch_taken) begin
      // Flush the wrong-path word; pc_d is left as is.
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (w_load) begin
      r_instr_d <= imem_rd;
      r_pc_d    <= w_pc;
      r_valid_d <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  word_t r_fetch_count;
  word_t r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_load)       r_fetch_count <= r_fetch_count + 32'd1;
      if (branch_taken) r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

  assign imem_addr  = w_pc;
  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus8_d = r_pc_d + PC_R15_OFFSET;
  assign valid_d    = r_valid_d;

endmodule
